bus_ram_slave: RTL and testbench

BUS_RAM_SLAVE -- requirements
Module: bus_ram_slave

---
 rtl/bus_ram_slave.sv | 129 ++++++++++++
 tb/tb_bus_ram_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_slave.sv
// Bus-attached RAM slave: a 2^ADDR_WIDTH x 32-bit word window at BASE_ADDR.
// Burst reads and byte-enabled burst writes are supported, and misaligned
// accesses are rejected. Every output is registered and stays 0 while idle,
// so several slaves can be OR-combined onto a shared return bus.
module bus_ram_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StRdFetch,
    StRdData,
    StWrData,
    StErr
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [8:0]            beats_left;
  logic [3:0]            byte_en;
  logic [31:0]           mem [Depth];
  logic [31:0]           rd_word;
  logic                  sel;
  logic                  wr_en;

  assign sel = bus_beginTransaction_i &&
               (bus_addrData_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign wr_en = (state == StWrData) && bus_dataValid_i;

  // Block RAM: byte-lane gated write and synchronous read of the current word.
  // Contents are deliberately not reset so they survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= bus_addrData_i[8*b +: 8];
      end
    end
    rd_word <= mem[word_idx];
  end

  // Transaction FSM with registered bus outputs; outputs default to 0 each cycle.
  // Reads: RdFetch primes the RAM pipeline one word ahead, so RdData can stream
  // one beat per cycle while the next word is being fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= StIdle;
      word_idx             <= '0;
      beats_left           <= '0;
      byte_en              <= '0;
      bus_addrData_o       <= '0;
      bus_endTransaction_o <= 1'b0;
      bus_dataValid_o      <= 1'b0;
      bus_busy_o           <= 1'b0;
      bus_error_o          <= 1'b0;
    end else begin
      bus_addrData_o       <= '0;
      bus_endTransaction_o <= 1'b0;
      bus_dataValid_o      <= 1'b0;
      bus_busy_o           <= 1'b0;
      bus_error_o          <= 1'b0;
      unique case (state)
        StIdle: begin
          if (sel) begin
            if (bus_addrData_i[1:0] != 2'b00) begin
              state <= StErr;
            end else begin
              word_idx <= bus_addrData_i[ADDR_WIDTH+1:2];
              if (bus_readNWrite_i) begin
                beats_left <= {1'b0, bus_burstSize_i} + 9'd1;
                state      <= StRdFetch;
              end else begin
                byte_en <= bus_byteEnables_i;
                state   <= StWrData;
              end
            end
          end
        end
        StErr: begin
          bus_error_o          <= 1'b1;
          bus_endTransaction_o <= 1'b1;
          state                <= StIdle;
        end
        StRdFetch: begin
          bus_busy_o <= 1'b1;
          word_idx   <= word_idx + ADDR_WIDTH'(1);
          state      <= StRdData;
        end
        StRdData: begin
          bus_busy_o      <= 1'b1;
          bus_dataValid_o <= 1'b1;
          bus_addrData_o  <= rd_word;
          if (beats_left == 9'd1) begin
            bus_endTransaction_o <= 1'b1;
            state                <= StIdle;
          end else begin
            beats_left <= beats_left - 9'd1;
            word_idx   <= word_idx + ADDR_WIDTH'(1);
          end
        end
        StWrData: begin
          if (bus_dataValid_i) begin
            word_idx <= word_idx + ADDR_WIDTH'(1);
            if (bus_endTransaction_i) state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed plus randomized bench for bus_ram_slave against a word-array model.
module tb_bus_ram_slave;

  localparam logic [31:0] Base  = 32'h1000_0000;
  localparam int unsigned Words = 1024;

  logic        clk;
  logic        rst_n;
  logic [31:0] ad_i;
  logic [3:0]  be_i;
  logic [7:0]  bs_i;
  logic        rnw_i;
  logic        begin_i;
  logic        end_i;
  logic        dv_i;
  logic [31:0] ad_o;
  logic        end_o;
  logic        dv_o;
  logic        busy_o;
  logic        err_o;
  logic [35:0] outs;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [Words];
  logic [31:0] wbuf  [Words];

  bus_ram_slave #(
    .BASE_ADDR  (Base),
    .ADDR_WIDTH (10)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .bus_addrData_i         (ad_i),
    .bus_byteEnables_i      (be_i),
    .bus_burstSize_i        (bs_i),
    .bus_readNWrite_i       (rnw_i),
    .bus_beginTransaction_i (begin_i),
    .bus_endTransaction_i   (end_i),
    .bus_dataValid_i        (dv_i),
    .bus_addrData_o         (ad_o),
    .bus_endTransaction_o   (end_o),
    .bus_dataValid_o        (dv_o),
    .bus_busy_o             (busy_o),
    .bus_error_o            (err_o)
  );

  assign outs = {ad_o, end_o, dv_o, busy_o, err_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    begin_i = 1'b0;
    end_i   = 1'b0;
    dv_i    = 1'b0;
    ad_i    = '0;
    be_i    = '0;
    bs_i    = '0;
    rnw_i   = 1'b0;
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % Words;
  endfunction

  // Burst write of wbuf[0..n-1]; occasionally inserts a non-valid cycle.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int n,
                          input bit gaps);
    int unsigned idx;
    idx     = widx(addr);
    begin_i = 1'b1;
    ad_i    = addr;
    be_i    = be;
    bs_i    = 8'(n - 1);
    rnw_i   = 1'b0;
    tick();
    idle_in();
    check("wr_begin", outs, '0);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ad_i  = $urandom;
        dv_i  = 1'b0;
        end_i = 1'($urandom_range(0, 1));
        tick();
        check("wr_gap", outs, '0);
      end
      ad_i  = wbuf[k];
      dv_i  = 1'b1;
      end_i = (k == n - 1);
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[idx][8*b +: 8] = wbuf[k][8*b +: 8];
      end
      idx = (idx + 1) % Words;
      tick();
      check("wr_beat", outs, '0);
    end
    idle_in();
  endtask

  // Burst read of n words; with noise, stray begins are driven during the beats.
  task automatic do_read(input logic [31:0] addr, input int n, input bit noise);
    int unsigned idx;
    idx     = widx(addr);
    begin_i = 1'b1;
    ad_i    = addr;
    be_i    = 4'($urandom);
    bs_i    = 8'(n - 1);
    rnw_i   = 1'b1;
    tick();
    idle_in();
    check("rd_t0", outs, '0);
    tick();
    check("rd_t1", outs, {32'h0, 4'b0010});
    for (int k = 0; k < n; k++) begin
      if (noise && k < n - 1) begin
        begin_i = 1'b1;
        ad_i    = Base | 32'h1;
        rnw_i   = 1'($urandom);
      end else begin
        idle_in();
      end
      tick();
      check("rd_beat", outs, {model[idx], (k == n - 1), 1'b1, 1'b1, 1'b0});
      idx = (idx + 1) % Words;
    end
    idle_in();
    tick();
    check("rd_after", outs, '0);
  endtask

  task automatic do_err(input logic [31:0] addr);
    begin_i = 1'b1;
    ad_i    = addr;
    rnw_i   = 1'($urandom);
    bs_i    = 8'($urandom);
    tick();
    idle_in();
    check("err_t0", outs, '0);
    tick();
    check("err_t1", outs, {32'h0, 4'b1001});
    tick();
    check("err_after", outs, '0);
  endtask

  task automatic do_unsel(input logic [31:0] addr);
    begin_i = 1'b1;
    ad_i    = addr;
    rnw_i   = 1'($urandom);
    tick();
    idle_in();
    dv_i  = 1'b1;
    end_i = 1'b1;
    ad_i  = $urandom;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("unsel", outs, '0);
    end
    idle_in();
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    idle_in();
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset", outs, '0);
    rst_n = 1'b1;
    tick();
    check("post_reset", outs, '0);

    // Fill the whole window so every later read has a defined model value.
    for (int i = 0; i < Words; i++) wbuf[i] = $urandom;
    do_write(Base, 4'hF, Words, 1'b0);

    wbuf[0] = 32'hDEAD_BEEF;
    do_write(Base + 32'h10, 4'hF, 1, 1'b0);
    do_read(Base + 32'h10, 1, 1'b0);

    wbuf[0] = 32'h1122_3344;
    do_write(Base + 32'h20, 4'hF, 1, 1'b0);
    wbuf[0] = 32'hAABB_CCDD;
    do_write(Base + 32'h20, 4'b0101, 1, 1'b0);
    do_read(Base + 32'h20, 1, 1'b0);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(Base + 32'hFF8, 4'hF, 4, 1'b0);
    do_read(Base + 32'hFF8, 4, 1'b0);

    do_err(Base + 32'h2);
    do_read(Base, 1, 1'b0);
    do_unsel(32'h2000_0000);
    do_read(Base + 32'h10, 2, 1'b0);

    // Reset in the middle of an 8-beat read.
    begin_i = 1'b1;
    ad_i    = Base + 32'h10;
    bs_i    = 8'd7;
    rnw_i   = 1'b1;
    tick();
    idle_in();
    tick();
    tick();
    check("abort_b1", outs, {model[4], 4'b0110});
    tick();
    check("abort_b2", outs, {model[5], 4'b0110});
    #2 rst_n = 1'b0;
    #1 check("abort_async", outs, '0);
    tick();
    check("abort_hold", outs, '0);
    rst_n = 1'b1;
    do_read(Base + 32'h10, 1, 1'b0);

    do_read(Base + (32'($urandom_range(0, Words - 1)) << 2), 256, 1'b1);

    for (int t = 0; t < 40; t++) begin
      a = Base + (32'($urandom_range(0, Words - 1)) << 2);
      case ($urandom_range(0, 5))
        0, 1: begin
          n = $urandom_range(1, 8);
          for (int i = 0; i < n; i++) wbuf[i] = $urandom;
          do_write(a, 4'($urandom), n, 1'b1);
        end
        2, 3: do_read(a, $urandom_range(1, 16), 1'($urandom));
        4: do_err(a | 32'($urandom_range(1, 3)));
        default: do_unsel(a ^ (32'($urandom_range(1, 255)) << 24));
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
